// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// mc_control : multi-cycle RV32 subset control FSM with retired-instr counter
// Revision   : 1.0 - initial release
// ============================================================================
module mc_control #(
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       ready;
  logic [2:0] exec_alu;
  logic       exec_ok;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // subtract only for R-type (opcode bit 5) with funct7 bit 5 set
  always_comb begin
    exec_alu = 3'b000;
    exec_ok  = 1'b1;
    case (funct3)
      3'b000:  exec_alu = (opcode[5] && instr[30]) ? 3'b001 : 3'b000;
      3'b010:  exec_alu = 3'b101;
      3'b110:  exec_alu = 3'b011;
      3'b111:  exec_alu = 3'b010;
      default: exec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_count_d = instr_count_q;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    imm_src       = 2'b00;
    alu_control   = 3'b000;
    trap          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_R)                state_d = S_EXECR;
        else if (opcode == OP_I)                state_d = S_EXECI;
        else if (opcode == OP_BR && funct3 == 3'b000) state_d = S_BEQ;
        else if (opcode == OP_JAL)              state_d = S_JAL;
        else                                    state_d = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = opcode[5] ? 2'b01 : 2'b00;
        state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        state_d       = S_FETCH;
        instr_count_d = instr_count_q + CNT_W'(1);
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (ready) begin
          state_d       = S_FETCH;
          instr_count_d = instr_count_q + CNT_W'(1);
        end
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = exec_alu;
        state_d     = exec_ok ? S_ALUWB : S_TRAP;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = exec_alu;
        state_d     = exec_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write     = 1'b1;
        state_d       = S_FETCH;
        instr_count_d = instr_count_q + CNT_W'(1);
      end
      S_BEQ: begin
        alu_src_a     = 2'b10;
        alu_control   = 3'b001;
        pc_write      = zero;
        state_d       = S_FETCH;
        instr_count_d = instr_count_q + CNT_W'(1);
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_write    = 1'b1;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// tb_mc_control : directed self-checking bench for mc_control
// Revision      : 1.0 - initial release
// ============================================================================
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [31:0] instr, instr2;
  logic        zero, mem_ready;

  logic        pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, trap;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instr_count;

  logic        pc_write2, adr_src2, mem_read2, mem_write2, ir_write2, reg_write2, trap2;
  logic [1:0]  result_src2, alu_src_a2, alu_src_b2, imm_src2;
  logic [2:0]  alu_control2;
  logic [3:0]  instr_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .trap(trap), .instr_count(instr_count)
  );

  mc_control #(.CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .instr(instr2), .zero(1'b0), .mem_ready(1'b0),
    .pc_write(pc_write2), .adr_src(adr_src2), .mem_read(mem_read2), .mem_write(mem_write2),
    .ir_write(ir_write2), .reg_write(reg_write2), .result_src(result_src2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .imm_src(imm_src2),
    .alu_control(alu_control2), .trap(trap2), .instr_count(instr_count2)
  );

  logic [17:0] ctl, ctl2;
  assign ctl  = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control, trap};
  assign ctl2 = {pc_write2, adr_src2, mem_read2, mem_write2, ir_write2, reg_write2,
                 result_src2, alu_src_a2, alu_src_b2, imm_src2, alu_control2, trap2};

  function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic tr);
    return {pcw, adr, mr, mw, irw, rw, rs, a, b, imm, alu, tr};
  endfunction

  localparam logic [17:0] V_FETCH    = pk(1,0,1,0,1,0,2'd2,2'd0,2'd2,2'd0,3'd0,0);
  localparam logic [17:0] V_FETCHW   = pk(0,0,1,0,0,0,2'd2,2'd0,2'd2,2'd0,3'd0,0);
  localparam logic [17:0] V_DECODE   = pk(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd2,3'd0,0);
  localparam logic [17:0] V_MEMADR_L = pk(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'd0,0);
  localparam logic [17:0] V_MEMADR_S = pk(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd1,3'd0,0);
  localparam logic [17:0] V_MEMREAD  = pk(0,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0);
  localparam logic [17:0] V_MEMWB    = pk(0,0,0,0,0,1,2'd1,2'd0,2'd0,2'd0,3'd0,0);
  localparam logic [17:0] V_MEMWRITE = pk(0,1,0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0);
  localparam logic [17:0] V_ALUWB    = pk(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,3'd0,0);
  localparam logic [17:0] V_JAL      = pk(1,0,0,0,0,0,2'd0,2'd1,2'd2,2'd0,3'd0,0);
  localparam logic [17:0] V_TRAP     = pk(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,1);

  function automatic logic [17:0] v_execr(input logic [2:0] alu);
    return pk(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd0,alu,0);
  endfunction
  function automatic logic [17:0] v_execi(input logic [2:0] alu);
    return pk(0,0,0,0,0,0,2'd0,2'd2,2'd1,2'd0,alu,0);
  endfunction
  function automatic logic [17:0] v_beq(input logic z);
    return pk(z,0,0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'd1,0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1: check settled outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [17:0] e);
    #1;
    check(tag, {14'd0, ctl}, {14'd0, e});
    @(posedge clk); #1;
  endtask

  task automatic cyc2(input string tag, input logic [17:0] e);
    #1;
    check(tag, {14'd0, ctl2}, {14'd0, e});
    @(posedge clk); #1;
  endtask

  logic [31:0] rtab [2] = '{32'h0020A1B3, 32'h0020E1B3};
  logic [2:0]  atab [2] = '{3'b101, 3'b011};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; instr = 32'h0; instr2 = 32'h0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_count", instr_count, 32'd0);
    check("reset_trap", {31'd0, trap}, 32'd0);

    instr = 32'h002081B3;
    cyc("add_fetch", V_FETCH);
    cyc("add_decode", V_DECODE);
    cyc("add_execr", v_execr(3'b000));
    cyc("add_aluwb", V_ALUWB);
    check("add_count", instr_count, 32'd1);

    instr = 32'h402081B3;
    cyc("sub_fetch", V_FETCH);
    cyc("sub_decode", V_DECODE);
    cyc("sub_execr", v_execr(3'b001));
    cyc("sub_aluwb", V_ALUWB);

    instr = 32'h40008193;
    cyc("addi_fetch", V_FETCH);
    cyc("addi_decode", V_DECODE);
    cyc("addi_execi", v_execi(3'b000));
    cyc("addi_aluwb", V_ALUWB);
    check("count_3", instr_count, 32'd3);

    for (int i = 0; i < 2; i++) begin
      instr = rtab[i];
      cyc("rop_fetch", V_FETCH);
      cyc("rop_decode", V_DECODE);
      cyc("rop_execr", v_execr(atab[i]));
      cyc("rop_aluwb", V_ALUWB);
    end

    // lw with three wait states in MEMREAD
    instr = 32'h0000A083;
    cyc("lw_fetch", V_FETCH);
    cyc("lw_decode", V_DECODE);
    cyc("lw_memadr", V_MEMADR_L);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", V_MEMREAD);
    mem_ready = 1'b1;
    cyc("lw_memread_done", V_MEMREAD);
    cyc("lw_memwb", V_MEMWB);
    check("lw_count", instr_count, 32'd6);

    // sw with one wait state; mem_write held while waiting
    instr = 32'h0010A023;
    cyc("sw_fetch", V_FETCH);
    cyc("sw_decode", V_DECODE);
    cyc("sw_memadr", V_MEMADR_S);
    mem_ready = 1'b0;
    cyc("sw_memwrite_wait", V_MEMWRITE);
    mem_ready = 1'b1;
    cyc("sw_memwrite_done", V_MEMWRITE);
    check("sw_count", instr_count, 32'd7);

    instr = 32'h00208063;
    zero = 1'b1;
    cyc("beq_t_fetch", V_FETCH);
    cyc("beq_t_decode", V_DECODE);
    cyc("beq_taken", v_beq(1'b1));
    check("beq_t_count", instr_count, 32'd8);
    zero = 1'b0;
    cyc("beq_n_fetch", V_FETCH);
    cyc("beq_n_decode", V_DECODE);
    cyc("beq_not_taken", v_beq(1'b0));
    check("beq_n_count", instr_count, 32'd9);

    // fetch stalls once before jal
    instr = 32'h0000006F;
    mem_ready = 1'b0;
    cyc("jal_fetch_wait", V_FETCHW);
    mem_ready = 1'b1;
    cyc("jal_fetch", V_FETCH);
    cyc("jal_decode", V_DECODE);
    cyc("jal_jal", V_JAL);
    cyc("jal_aluwb", V_ALUWB);
    check("jal_count", instr_count, 32'd10);

    // R-type with unsupported funct3 traps after execute
    instr = 32'h002091B3;
    cyc("badf3_fetch", V_FETCH);
    cyc("badf3_decode", V_DECODE);
    cyc("badf3_execr", v_execr(3'b000));
    cyc("badf3_trap", V_TRAP);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_from_trap_count", instr_count, 32'd0);

    instr = 32'h0000007F;
    cyc("illop_fetch", V_FETCH);
    cyc("illop_decode", V_DECODE);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      zero      = i[1];
      cyc("illop_trap", V_TRAP);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("after_rst_fetch", V_FETCH);

    // narrow counter without handshake: 16 adds then sw
    rst2 = 1'b0;
    instr2 = 32'h002081B3;
    repeat (64) @(posedge clk);
    #1;
    check("wrap_count_16", {28'd0, instr_count2}, 32'd0);
    instr2 = 32'h0010A023;
    cyc2("nh_sw_fetch", V_FETCH);
    cyc2("nh_sw_decode", V_DECODE);
    cyc2("nh_sw_memadr", V_MEMADR_S);
    cyc2("nh_sw_memwrite", V_MEMWRITE);
    cyc2("nh_sw_back_fetch", V_FETCH);
    check("wrap_count_17", {28'd0, instr_count2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
